// File: rtl/universal_mod_cnt.sv
// universal_mod_cnt: up/down counter over the range 0..MOD-1 with a variable
// step, run-time selectable wrap or saturate behaviour, combinational end
// ticks and registered one-cycle wrap / bad-load pulses.
module universal_mod_cnt #(
  parameter int N      = 8,
  parameter int MOD    = 200,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              syn_clr,
  input  logic              load,
  input  logic              en,
  input  logic              up,
  input  logic              sat,
  input  logic [STEP_W-1:0] step,
  input  logic [N-1:0]      d,
  output logic [N-1:0]      q,
  output logic              max_tick,
  output logic              min_tick,
  output logic              wrap_pls,
  output logic              load_err
);

  // Reject parameter sets where one correction by MOD could be insufficient.
  if ((MOD < 2) || (MOD > (1 << N)) || ((1 << STEP_W) > MOD)) begin : g_param_chk
    $error("universal_mod_cnt: illegal N/MOD/STEP_W combination");
  end

  // All arithmetic runs one bit wider than q so MOD == 2**N is representable.
  localparam logic [N:0]   MOD_EXT = (N+1)'(MOD);
  localparam logic [N-1:0] TOP_VAL = (N)'(MOD - 1);

  logic [N-1:0] q_r;
  logic         wrap_r;
  logic         err_r;

  logic [N-1:0] q_nxt_s;
  logic         wrap_nxt_s;
  logic         err_nxt_s;

  logic [N:0]   q_ext_s;
  logic [N:0]   step_ext_s;
  logic [N:0]   d_ext_s;
  logic [N:0]   sum_s;
  logic [N:0]   over_s;
  logic [N:0]   under_s;

  assign q_ext_s    = {1'b0, q_r};
  assign step_ext_s = {{(N+1-STEP_W){1'b0}}, step};
  assign d_ext_s    = {1'b0, d};
  assign sum_s      = q_ext_s + step_ext_s;
  // Up-count overflow corrected once by MOD; result always lands in range.
  assign over_s     = sum_s - MOD_EXT;
  // Down-count underflow corrected once by MOD; q + MOD never exceeds N+1 bits.
  assign under_s    = q_ext_s + MOD_EXT - step_ext_s;

  // Next-state selection with priority syn_clr > load > en > hold.
  always_comb begin
    q_nxt_s    = q_r;
    wrap_nxt_s = 1'b0;
    err_nxt_s  = 1'b0;
    if (syn_clr) begin
      q_nxt_s = {N{1'b0}};
    end else if (load) begin
      if (d_ext_s >= MOD_EXT) begin
        q_nxt_s   = TOP_VAL;
        err_nxt_s = 1'b1;
      end else begin
        q_nxt_s = d;
      end
    end else if (en) begin
      if (step == {STEP_W{1'b0}}) begin
        q_nxt_s = q_r;
      end else if (up) begin
        if (sum_s >= MOD_EXT) begin
          if (sat) begin
            q_nxt_s = TOP_VAL;
          end else begin
            q_nxt_s    = over_s[N-1:0];
            wrap_nxt_s = 1'b1;
          end
        end else begin
          q_nxt_s = sum_s[N-1:0];
        end
      end else begin
        if (q_ext_s >= step_ext_s) begin
          q_nxt_s = q_r - step_ext_s[N-1:0];
        end else if (sat) begin
          q_nxt_s = {N{1'b0}};
        end else begin
          q_nxt_s    = under_s[N-1:0];
          wrap_nxt_s = 1'b1;
        end
      end
    end else begin
      q_nxt_s = q_r;
    end
  end

  // Count register and pulse flops; reset clears them without a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r    <= {N{1'b0}};
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      wrap_r <= wrap_nxt_s;
      err_r  <= err_nxt_s;
    end
  end

  assign q        = q_r;
  assign wrap_pls = wrap_r;
  assign load_err = err_r;
  assign max_tick = (q_r == TOP_VAL);
  assign min_tick = (q_r == {N{1'b0}});

endmodule

// File: tb/tb_universal_mod_cnt.sv
// Self-checking bench for universal_mod_cnt: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against an
// integer-arithmetic reference model.
module tb_universal_mod_cnt;

  localparam int N      = 8;
  localparam int MOD    = 200;
  localparam int STEP_W = 4;

  logic              clk;
  logic              rst;
  logic              syn_clr;
  logic              load;
  logic              en;
  logic              up;
  logic              sat;
  logic [STEP_W-1:0] step;
  logic [N-1:0]      d;
  logic [N-1:0]      q;
  logic              max_tick;
  logic              min_tick;
  logic              wrap_pls;
  logic              load_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  int mq = 0;
  int mw = 0;
  int me = 0;

  universal_mod_cnt #(.N(N), .MOD(MOD), .STEP_W(STEP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .syn_clr  (syn_clr),
    .load     (load),
    .en       (en),
    .up       (up),
    .sat      (sat),
    .step     (step),
    .d        (d),
    .q        (q),
    .max_tick (max_tick),
    .min_tick (min_tick),
    .wrap_pls (wrap_pls),
    .load_err (load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // literal expectation applied both to the DUT and to the model
  task automatic lit(input string name, input int exp_q);
    chk(name, int'(q), exp_q);
    chk({name, "_model"}, mq, exp_q);
  endtask

  // model: async reset clears everything at once
  always @(negedge rst) begin
    mq = 0;
    mw = 0;
    me = 0;
  end

  // model update at each rising edge, then compare all outputs 1ns later
  always @(posedge clk) begin
    int s;
    if (!rst) begin
      mq = 0;
      mw = 0;
      me = 0;
    end else begin
      mw = 0;
      me = 0;
      if (syn_clr) begin
        mq = 0;
      end else if (load) begin
        if (int'(d) >= MOD) begin
          mq = MOD - 1;
          me = 1;
        end else begin
          mq = int'(d);
        end
      end else if (en) begin
        if (up) begin
          s = mq + int'(step);
          if (s >= MOD) begin
            if (sat) mq = MOD - 1;
            else begin mq = s - MOD; mw = 1; end
          end else mq = s;
        end else begin
          s = mq - int'(step);
          if (s < 0) begin
            if (sat) mq = 0;
            else begin mq = s + MOD; mw = 1; end
          end else mq = s;
        end
      end
    end
    #1;
    chk("q", int'(q), mq);
    chk("wrap_pls", int'(wrap_pls), mw);
    chk("load_err", int'(load_err), me);
    chk("max_tick", int'(max_tick), (mq == MOD - 1) ? 1 : 0);
    chk("min_tick", int'(min_tick), (mq == 0) ? 1 : 0);
  end

  task automatic edge_wait();
    @(posedge clk);
    #2;
  endtask

  task automatic ctl(input logic c, input logic l, input logic e, input logic u,
                     input logic s, input int st, input int dv);
    syn_clr = c;
    load    = l;
    en      = e;
    up      = u;
    sat     = s;
    step    = STEP_W'(st);
    d       = N'(dv);
  endtask

  initial begin
    rst = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
    repeat (2) edge_wait();
    lit("reset_q", 0);
    chk("reset_wrap", int'(wrap_pls), 0);
    chk("reset_err", int'(load_err), 0);

    // 1: count to 37, async reset mid-cycle, then restart
    rst = 1'b1;
    ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0);
    repeat (37) edge_wait();
    lit("count37", 37);
    #1 rst = 1'b0;
    #1;
    lit("async_rst_q", 0);
    chk("async_rst_wrap", int'(wrap_pls), 0);
    rst = 1'b1;
    edge_wait(); lit("restart1", 1);
    edge_wait(); lit("restart2", 2);
    edge_wait(); lit("restart3", 3);

    // 2: up wrap by stride jumping over MOD-1
    ctl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3, 198);
    edge_wait(); lit("load198", 198);
    ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3, 0);
    edge_wait(); lit("upwrap_q", 1);
    chk("upwrap_pls", int'(wrap_pls), 1);
    chk("upwrap_maxtick", int'(max_tick), 0);
    edge_wait(); lit("upwrap_next", 4);
    chk("upwrap_pls_drop", int'(wrap_pls), 0);

    // 3: down wrap
    ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5, 2);
    edge_wait(); lit("load2", 2);
    ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5, 0);
    edge_wait(); lit("dnwrap_q", 197);
    chk("dnwrap_pls", int'(wrap_pls), 1);
    edge_wait(); lit("dnwrap_next", 192);

    // 4: saturation at both ends
    ctl(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4, 195);
    edge_wait(); lit("load195", 195);
    ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4, 0);
    edge_wait(); lit("sat_up", 199);
    chk("sat_up_maxtick", int'(max_tick), 1);
    edge_wait(); lit("sat_up_hold", 199);
    chk("sat_up_nowrap", int'(wrap_pls), 0);
    ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5, 3);
    edge_wait(); lit("load3", 3);
    ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5, 0);
    edge_wait(); lit("sat_dn", 0);
    chk("sat_dn_mintick", int'(min_tick), 1);

    // 5: out-of-range load
    ctl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 250);
    edge_wait(); lit("load250", 199);
    chk("load250_err", int'(load_err), 1);
    ctl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 120);
    edge_wait(); lit("load120", 120);
    chk("load120_err", int'(load_err), 0);

    // 6: priority and zero step
    ctl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 50);
    edge_wait(); lit("load50", 50);
    ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 10);
    edge_wait(); lit("prio_clr", 0);
    ctl(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 10);
    edge_wait(); lit("prio_load", 10);
    ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    edge_wait(); lit("step0", 10);
    chk("step0_wrap", int'(wrap_pls), 0);
    chk("step0_err", int'(load_err), 0);

    // randomized run, compared every cycle by the model process
    for (int i = 0; i < 3000; i++) begin
      syn_clr = ($urandom_range(0, 49) == 0);
      load    = ($urandom_range(0, 9) == 0);
      en      = ($urandom_range(0, 3) != 0);
      up      = $urandom_range(0, 1) == 1;
      sat     = ($urandom_range(0, 3) == 0);
      step    = STEP_W'($urandom_range(0, (1 << STEP_W) - 1));
      d       = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b0;
        edge_wait();
        rst = 1'b1;
      end else begin
        edge_wait();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
